// File: rtl/lib_cpu_pkg.sv
// lib_cpu: shared execution-controller types and speed encodings for the 4-bit CPU.
package lib_cpu;
  typedef enum logic [1:0] {ST_HALT, ST_RUN, ST_STEP} EXEC_STATE;
  typedef logic [1:0] SPEED;
  localparam SPEED SPD_EVERY = 2'b00;
  localparam SPEED SPD_FAST = 2'b01;
  localparam SPEED SPD_SLOW = 2'b10;
endpackage

// File: rtl/exec_ctrl_tick_div.sv
// tick_div: free-run tick divider; compare is against the currently selected limit.
module tick_div
  import lib_cpu::*;
#(
  parameter int DIV_FAST = 5_000_000,
  parameter int DIV_SLOW = 50_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       clr,
  input  logic [1:0] speed_sel,
  output logic       tick
);
  localparam int CW = DIV_SLOW > 2 ? $clog2(DIV_SLOW) : 1;
  localparam logic [CW-1:0] FAST_M1 = CW'(DIV_FAST - 1);
  localparam logic [CW-1:0] SLOW_M1 = CW'(DIV_SLOW - 1);
  logic [CW-1:0] cnt_q, cnt_d, lim;
  // >= so a speed change to a shorter period fires at once instead of running past the limit
  always_comb begin
    lim = speed_sel == SPD_EVERY ? '0 : speed_sel == SPD_FAST ? FAST_M1 : SLOW_M1;
    tick = !clr && cnt_q >= lim;
    cnt_d = (clr || tick) ? '0 : cnt_q + CW'(1);
  end
  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else cnt_q <= cnt_d;
  end
endmodule

// File: rtl/exec_ctrl.sv
// exec_ctrl: run/halt/step/breakpoint sequencer owning the program RAM and loader arbitration.
module exec_ctrl
  import lib_cpu::*;
#(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8,
  parameter int DIV_FAST = 5_000_000,
  parameter int DIV_SLOW = 50_000_000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              run_req,
  input  logic              halt_req,
  input  logic              step_req,
  input  logic [1:0]        speed_sel,
  input  logic              bp_en,
  input  logic [ADDR_W-1:0] bp_addr,
  input  logic [ADDR_W-1:0] cpu_ip,
  output logic [DATA_W-1:0] cpu_data,
  output logic              cpu_en,
  input  logic              prog_we,
  input  logic [ADDR_W-1:0] prog_addr,
  input  logic [DATA_W-1:0] prog_data,
  output logic              prog_ack,
  output logic              prog_err,
  output logic [1:0]        state,
  output logic              bp_hit
);
  EXEC_STATE state_q, state_d;
  logic bp_skip_q, bp_skip_d, ack_q, err_q, hit_q;
  logic tick, run_tick, bp_match, bp_stop, halted;
  logic [DATA_W-1:0] ram_q [2**ADDR_W];
  tick_div #(.DIV_FAST(DIV_FAST), .DIV_SLOW(DIV_SLOW)) u_div (
    .clk(clk), .reset(reset), .clr(state_q != ST_RUN), .speed_sel(speed_sel), .tick(tick)
  );
  // bp_skip lets a resumed run execute the instruction it was parked on
  always_comb begin
    halted = state_q == ST_HALT;
    run_tick = state_q == ST_RUN && !halt_req && tick;
    bp_match = bp_en && cpu_ip == bp_addr && !bp_skip_q;
    bp_stop = run_tick && bp_match;
    cpu_en = state_q == ST_STEP || (run_tick && !bp_match);
    state_d = halted ? (halt_req ? ST_HALT : run_req ? ST_RUN : step_req ? ST_STEP : ST_HALT) :
              state_q == ST_RUN ? ((halt_req || bp_stop) ? ST_HALT : ST_RUN) : ST_HALT;
    bp_skip_d = (halted && !halt_req && run_req) ? 1'b1 :
                (run_tick && !bp_match) ? 1'b0 : bp_skip_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_HALT;
      bp_skip_q <= 1'b0;
      ack_q <= 1'b0;
      err_q <= 1'b0;
      hit_q <= 1'b0;
      for (int i = 0; i < 2**ADDR_W; i++) ram_q[i] <= '0;
    end else begin
      state_q <= state_d;
      bp_skip_q <= bp_skip_d;
      ack_q <= prog_we && halted;
      err_q <= prog_we && !halted;
      hit_q <= bp_stop;
      if (prog_we && halted) ram_q[prog_addr] <= prog_data;
    end
  end
  assign cpu_data = ram_q[cpu_ip];
  assign prog_ack = ack_q;
  assign prog_err = err_q;
  assign bp_hit = hit_q;
  assign state = state_q;
endmodule

// File: tb/tb_exec_ctrl.sv
// tb_exec_ctrl: directed scenarios plus randomized traffic against a cycle-level behavioural model.
module tb_exec_ctrl;
  import lib_cpu::*;
  localparam int DF = 4;
  localparam int DS = 8;
  logic clk = 1'b0;
  logic reset, run_req, halt_req, step_req, bp_en, prog_we, cpu_en, prog_ack, prog_err, bp_hit;
  logic [1:0] speed_sel, state;
  logic [3:0] bp_addr, cpu_ip, prog_addr;
  logic [7:0] prog_data, cpu_data;
  int checks = 0;
  int errors = 0;
  int m_state, m_cnt, n_state, n_cnt, e_state;
  bit m_skip, m_ack, m_err, m_hit, n_skip, n_ack, n_err, n_hit, e_ack, e_err, e_hit, e_en;
  logic [7:0] m_mem [16];
  logic [7:0] e_data, o_data;
  logic o_en, o_ack, o_err, o_hit;
  logic [1:0] o_state;

  always #5 clk = ~clk;

  exec_ctrl #(.ADDR_W(4), .DATA_W(8), .DIV_FAST(DF), .DIV_SLOW(DS)) dut (
    .clk(clk), .reset(reset), .run_req(run_req), .halt_req(halt_req), .step_req(step_req),
    .speed_sel(speed_sel), .bp_en(bp_en), .bp_addr(bp_addr), .cpu_ip(cpu_ip), .cpu_data(cpu_data),
    .cpu_en(cpu_en), .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data),
    .prog_ack(prog_ack), .prog_err(prog_err), .state(state), .bp_hit(bp_hit)
  );

  // One clock: sample DUT and predict at negedge, advance the model at posedge, return #1 later.
  task automatic clk_cycle();
    int period;
    bit tk;
    @(negedge clk);
    o_en = cpu_en; o_state = state; o_data = cpu_data; o_ack = prog_ack; o_err = prog_err; o_hit = bp_hit;
    period = speed_sel == 2'd0 ? 1 : speed_sel == 2'd1 ? DF : DS;
    tk = m_state == 1 && m_cnt >= period - 1;
    e_en = 0; e_state = m_state; e_data = m_mem[cpu_ip]; e_ack = m_ack; e_err = m_err; e_hit = m_hit;
    n_state = m_state; n_skip = m_skip; n_hit = 0; n_ack = 0; n_err = 0;
    n_cnt = (m_state == 1 && !tk) ? m_cnt + 1 : 0;
    if (m_state == 0) begin
      if (!halt_req && run_req) begin n_state = 1; n_skip = 1; end
      else if (!halt_req && step_req) n_state = 2;
    end else if (m_state == 1) begin
      if (halt_req) n_state = 0;
      else if (tk) begin
        if (bp_en && cpu_ip == bp_addr && !m_skip) begin n_state = 0; n_hit = 1; end
        else begin e_en = 1; n_skip = 0; end
      end
    end else begin
      e_en = 1; n_state = 0;
    end
    if (prog_we) begin
      if (m_state == 0) n_ack = 1;
      else n_err = 1;
    end
    @(posedge clk);
    if (reset) begin
      m_state = 0; m_cnt = 0; m_skip = 0; m_ack = 0; m_err = 0; m_hit = 0;
      for (int i = 0; i < 16; i++) m_mem[i] = 8'h00;
    end else begin
      if (prog_we && m_state == 0) m_mem[prog_addr] = prog_data;
      m_state = n_state; m_cnt = n_cnt; m_skip = n_skip; m_ack = n_ack; m_err = n_err; m_hit = n_hit;
    end
    #1;
  endtask

  task automatic idle();
    reset = 0; run_req = 0; halt_req = 0; step_req = 0; prog_we = 0;
  endtask

  task automatic test_reset();
    idle(); speed_sel = 2'd0; bp_en = 0; bp_addr = 0; cpu_ip = 0; prog_addr = 0; prog_data = 0;
    reset = 1;
    clk_cycle();
    clk_cycle();
    reset = 0;
    clk_cycle();
    checks++;
    if (o_state !== ST_HALT || o_en !== 1'b0 || {o_ack, o_err, o_hit} !== 3'b000) begin
      errors++; $display("FAIL reset_state: state=%0d en=%b ack/err/hit=%b%b%b, want 0 0 000", o_state, o_en, o_ack, o_err, o_hit);
    end
    for (int i = 0; i < 16; i++) begin
      cpu_ip = 4'(i);
      clk_cycle();
      checks++;
      if (o_data !== 8'h00) begin errors++; $display("FAIL reset_ram[%0d]: got %h want 00", i, o_data); end
    end
  endtask

  task automatic test_prog_write();
    prog_we = 1; prog_addr = 4'd5; prog_data = 8'hB3;
    clk_cycle();
    prog_addr = 4'd0; prog_data = 8'h01;
    clk_cycle();
    checks++;
    if (o_ack !== 1'b1) begin errors++; $display("FAIL write_ack1: got %b want 1", o_ack); end
    prog_we = 0; cpu_ip = 4'd5;
    clk_cycle();
    checks++;
    if (o_ack !== 1'b1 || o_data !== 8'hB3) begin
      errors++; $display("FAIL write_ack2_read5: ack=%b data=%h want 1 b3", o_ack, o_data);
    end
    cpu_ip = 4'd0;
    clk_cycle();
    checks++;
    if (o_data !== 8'h01 || o_ack !== 1'b0) begin
      errors++; $display("FAIL read0: data=%h ack=%b want 01 0", o_data, o_ack);
    end
  endtask

  task automatic test_step();
    step_req = 1;
    clk_cycle();
    checks++;
    if (o_en !== 1'b0) begin errors++; $display("FAIL step_req_cycle_en: got %b want 0", o_en); end
    clk_cycle();
    checks++;
    if (o_en !== 1'b1 || o_state !== ST_STEP) begin
      errors++; $display("FAIL step_exec: en=%b state=%0d want 1 %0d", o_en, o_state, ST_STEP);
    end
    step_req = 0;
    clk_cycle();
    checks++;
    if (o_en !== 1'b0 || o_state !== ST_HALT) begin
      errors++; $display("FAIL step_back_to_halt: en=%b state=%0d want 0 0", o_en, o_state);
    end
  endtask

  task automatic test_run_fast();
    int n = 0;
    speed_sel = 2'd0; run_req = 1;
    clk_cycle();
    run_req = 0;
    repeat (5) begin
      clk_cycle();
      n += int'(o_en);
    end
    halt_req = 1;
    clk_cycle();
    checks++;
    if (o_en !== 1'b0) begin errors++; $display("FAIL run_fast_halt_cycle_en: got %b want 0", o_en); end
    halt_req = 0;
    clk_cycle();
    checks++;
    if (n != 5 || o_state !== ST_HALT) begin
      errors++; $display("FAIL run_fast: en_count=%0d state=%0d want 5 0", n, o_state);
    end
  endtask

  task automatic test_div();
    int n = 0;
    speed_sel = 2'd1; run_req = 1;
    clk_cycle();
    run_req = 0;
    for (int i = 1; i <= 12; i++) begin
      if (i == 6) begin prog_we = 1; prog_addr = 4'd5; prog_data = 8'hFF; end
      clk_cycle();
      prog_we = 0;
      n += int'(o_en);
      checks++;
      if (o_en !== 1'((i % 4) == 0) || o_en !== e_en) begin
        errors++; $display("FAIL div_en[%0d]: got %b want %b", i, o_en, (i % 4) == 0);
      end
      if (i == 7) begin
        checks++;
        if (o_err !== 1'b1 || o_ack !== 1'b0) begin
          errors++; $display("FAIL run_write_err: err=%b ack=%b want 1 0", o_err, o_ack);
        end
      end
    end
    halt_req = 1;
    clk_cycle();
    halt_req = 0; cpu_ip = 4'd5;
    clk_cycle();
    checks++;
    if (o_data !== 8'hB3 || n != 3) begin
      errors++; $display("FAIL run_write_ram: data=%h pulses=%0d want b3 3", o_data, n);
    end
  endtask

  task automatic test_breakpoint();
    speed_sel = 2'd0; bp_en = 1; bp_addr = 4'd3; cpu_ip = 4'd0; run_req = 1;
    clk_cycle();
    run_req = 0;
    for (int ip = 0; ip < 4; ip++) begin
      cpu_ip = 4'(ip);
      clk_cycle();
      checks++;
      if (o_en !== 1'(ip != 3)) begin errors++; $display("FAIL bp_en_ip%0d: got %b want %b", ip, o_en, ip != 3); end
    end
    clk_cycle();
    checks++;
    if (o_state !== ST_HALT || o_hit !== 1'b1) begin
      errors++; $display("FAIL bp_halt: state=%0d hit=%b want 0 1", o_state, o_hit);
    end
    run_req = 1;
    clk_cycle();
    run_req = 0;
    clk_cycle();
    checks++;
    if (o_en !== 1'b1 || o_state !== ST_RUN || o_hit !== 1'b0) begin
      errors++; $display("FAIL bp_resume: en=%b state=%0d hit=%b want 1 1 0", o_en, o_state, o_hit);
    end
    halt_req = 1;
    clk_cycle();
    halt_req = 0; bp_en = 0;
    clk_cycle();
  endtask

  task automatic test_priority();
    speed_sel = 2'd0; run_req = 1;
    clk_cycle();
    run_req = 0;
    clk_cycle();
    halt_req = 1; run_req = 1; step_req = 1;
    clk_cycle();
    checks++;
    if (o_en !== 1'b0 || o_state !== ST_RUN) begin
      errors++; $display("FAIL prio_cycle: en=%b state=%0d want 0 1", o_en, o_state);
    end
    idle();
    clk_cycle();
    checks++;
    if (o_state !== ST_HALT) begin errors++; $display("FAIL prio_halt: state=%0d want 0", o_state); end
  endtask

  task automatic test_reset_mid();
    run_req = 1;
    clk_cycle();
    run_req = 0;
    clk_cycle();
    reset = 1;
    clk_cycle();
    reset = 0;
    for (int i = 0; i < 16; i++) begin
      cpu_ip = 4'(i);
      clk_cycle();
      checks++;
      if (o_data !== 8'h00 || o_state !== ST_HALT || o_en !== 1'b0) begin
        errors++; $display("FAIL reset_mid[%0d]: data=%h state=%0d en=%b want 00 0 0", i, o_data, o_state, o_en);
      end
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 1500; c++) begin
      reset = $urandom_range(0, 199) == 0;
      run_req = $urandom_range(0, 19) == 0;
      halt_req = $urandom_range(0, 29) == 0;
      step_req = $urandom_range(0, 14) == 0;
      if ($urandom_range(0, 49) == 0) speed_sel = 2'($urandom_range(0, 3));
      bp_en = $urandom_range(0, 1) == 1;
      bp_addr = 4'($urandom_range(0, 3));
      cpu_ip = 4'($urandom_range(0, 15));
      prog_we = $urandom_range(0, 4) == 0;
      prog_addr = 4'($urandom_range(0, 15));
      prog_data = 8'($urandom);
      clk_cycle();
      checks++;
      if (o_en !== e_en || o_state !== 2'(e_state) || o_hit !== e_hit) begin
        errors++; $display("FAIL rand_ctrl[%0d]: en/state/hit=%b/%0d/%b want %b/%0d/%b", c, o_en, o_state, o_hit, e_en, e_state, e_hit);
      end
      checks++;
      if (o_data !== e_data || o_ack !== e_ack || o_err !== e_err) begin
        errors++; $display("FAIL rand_data[%0d]: data/ack/err=%h/%b/%b want %h/%b/%b", c, o_data, o_ack, o_err, e_data, e_ack, e_err);
      end
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_prog_write();
    test_step();
    test_run_fast();
    test_div();
    test_breakpoint();
    test_priority();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
